// File: rtl/led_breather_pkg.sv
// Shared phase encodings and parameter defaults for the breathing-LED driver.
package led_breather_pkg;

  localparam int PWM_BITS_DEF   = 8;
  localparam int HOLD_STEPS_DEF = 16;

  typedef enum logic [2:0] {
    PH_IDLE      = 3'd0,
    PH_RAMP_UP   = 3'd1,
    PH_HOLD_HIGH = 3'd2,
    PH_RAMP_DOWN = 3'd3,
    PH_HOLD_LOW  = 3'd4
  } phase_e;

  // Plateau counter width; kept at one bit even when plateaus are bypassed.
  function automatic int hold_width(input int steps);
    int w;
    w = $clog2(steps + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/led_breather_if.sv
// Control and observation bundle between the divider/LED pin side and the breather.
interface led_breather_if
  import led_breather_pkg::*;
  #(parameter int PWM_BITS = PWM_BITS_DEF) ();

  logic                enable;
  logic                step_in;
  logic                led_out;
  logic [PWM_BITS-1:0] duty_o;
  logic [2:0]          phase_o;

  modport master (
    output enable, step_in,
    input  led_out, duty_o, phase_o
  );

  modport slave (
    input  enable, step_in,
    output led_out, duty_o, phase_o
  );

endinterface

// File: rtl/led_breather_pwm_gen.sv
// Free-running PWM with a period-boundary duty shadow so each period is glitch-free.
module pwm_gen
  import led_breather_pkg::*;
  #(parameter int PWM_BITS = PWM_BITS_DEF)
  (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic [PWM_BITS-1:0] duty_in,
    output logic                out,
    output logic [PWM_BITS-1:0] duty_o
  );

  localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_active_q, duty_active_d;
  logic                out_q, out_d;

  // The shadow only follows duty_in on the last count, except for a forced dark clear.
  always_comb begin
    pwm_cnt_d     = pwm_cnt_q + 1'b1;
    duty_active_d = duty_active_q;
    if (clear) begin
      duty_active_d = '0;
    end else if (pwm_cnt_q == MAX) begin
      duty_active_d = duty_in;
    end
    out_d = (pwm_cnt_q < duty_active_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_q     <= '0;
      duty_active_q <= '0;
      out_q         <= 1'b0;
    end else begin
      pwm_cnt_q     <= pwm_cnt_d;
      duty_active_q <= duty_active_d;
      out_q         <= out_d;
    end
  end

  assign out    = out_q;
  assign duty_o = duty_active_q;

endmodule

// File: rtl/led_breather.sv
// Breathing envelope: ramps a duty target up and down on divider step edges,
// with hold plateaus at both ends, and feeds it to the PWM generator.
module led_breather
  import led_breather_pkg::*;
  #(
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter int HOLD_STEPS = HOLD_STEPS_DEF
  )
  (
    input  logic           clk,
    input  logic           reset_n,
    led_breather_if.slave  bus
  );

  localparam logic [PWM_BITS-1:0] MAX     = {PWM_BITS{1'b1}};
  localparam int                  HW      = hold_width(HOLD_STEPS);
  localparam logic [HW-1:0]       HOLD_LAST = HW'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);
  localparam bit                  NO_HOLD = (HOLD_STEPS == 0);

  phase_e              phase_q, phase_d;
  logic [PWM_BITS-1:0] duty_target_q, duty_target_d;
  logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
  logic                step_q, step_d;
  logic                step_pulse;
  logic                clear;
  logic                led_out;
  logic [PWM_BITS-1:0] duty_o;

  // enable low wins over any step edge arriving in the same cycle.
  always_comb begin
    step_d        = bus.step_in;
    step_pulse    = bus.step_in & ~step_q;
    clear         = ~bus.enable;
    phase_d       = phase_q;
    duty_target_d = duty_target_q;
    hold_cnt_d    = hold_cnt_q;

    if (!bus.enable) begin
      phase_d       = PH_IDLE;
      duty_target_d = '0;
      hold_cnt_d    = '0;
    end else begin
      case (phase_q)
        PH_IDLE: begin
          phase_d       = PH_RAMP_UP;
          duty_target_d = '0;
          hold_cnt_d    = '0;
        end
        PH_RAMP_UP: begin
          if (step_pulse) begin
            duty_target_d = duty_target_q + 1'b1;
            if (duty_target_q == MAX - 1'b1) begin
              phase_d = NO_HOLD ? PH_RAMP_DOWN : PH_HOLD_HIGH;
            end
          end
        end
        PH_HOLD_HIGH: begin
          if (step_pulse) begin
            if (hold_cnt_q == HOLD_LAST) begin
              phase_d    = PH_RAMP_DOWN;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end
        end
        PH_RAMP_DOWN: begin
          if (step_pulse) begin
            duty_target_d = duty_target_q - 1'b1;
            if (duty_target_q == {{(PWM_BITS-1){1'b0}}, 1'b1}) begin
              phase_d = NO_HOLD ? PH_RAMP_UP : PH_HOLD_LOW;
            end
          end
        end
        PH_HOLD_LOW: begin
          if (step_pulse) begin
            if (hold_cnt_q == HOLD_LAST) begin
              phase_d    = PH_RAMP_UP;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          phase_d = PH_IDLE;
        end
      endcase
    end
  end

  // step_q resets high so a step_in already high at release is not a step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q       <= PH_IDLE;
      duty_target_q <= '0;
      hold_cnt_q    <= '0;
      step_q        <= 1'b1;
    end else begin
      phase_q       <= phase_d;
      duty_target_q <= duty_target_d;
      hold_cnt_q    <= hold_cnt_d;
      step_q        <= step_d;
    end
  end

  pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .duty_in (duty_target_q),
    .out     (led_out),
    .duty_o  (duty_o)
  );

  assign bus.led_out = led_out;
  assign bus.duty_o  = duty_o;
  assign bus.phase_o = phase_q;

endmodule

// File: tb/tb_led_breather.sv
// Scoreboard bench for led_breather at PWM_BITS=4, HOLD_STEPS=2.
module tb_led_breather;
  import led_breather_pkg::*;

  localparam int PB = 4;
  localparam int HS = 2;
  localparam logic [PB-1:0] PMAX = {PB{1'b1}};

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int vec_cnt = 0;
  int miss_cnt = 0;
  int cyc = 0;
  int step_cyc = 0;
  logic [PB-1:0] tb_cnt = '0;

  int exp_phase_q[$];
  int exp_duty_q[$];
  int exp_high_q[$];

  led_breather_if #(.PWM_BITS(PB)) bus ();

  led_breather #(.PWM_BITS(PB), .HOLD_STEPS(HS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference period counter used to align high-time windows.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_cnt <= '0;
    else          tb_cnt <= tb_cnt + 1'b1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vec_cnt++;
    if (actual !== expected) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic noteTimeout(input string name);
    vec_cnt++;
    miss_cnt++;
    $display("[TB] FAIL %s: wait expired (t=%0t)", name, $time);
  endtask

  // Phase monitor: every observed phase change must match the next queued phase.
  logic [2:0] last_phase = 3'd0;
  always @(negedge clk) begin
    if (bus.phase_o !== last_phase) begin
      last_phase = bus.phase_o;
      if (exp_phase_q.size() == 0) begin
        vec_cnt++;
        miss_cnt++;
        $display("[TB] FAIL phase_unexpected: got %0d, expected no change", bus.phase_o);
      end else begin
        checkOutput("phase", int'(bus.phase_o), exp_phase_q.pop_front());
      end
    end
  end

  // Duty monitor: every applied-duty change must match the queue and arrive promptly.
  logic [PB-1:0] last_duty = '0;
  always @(negedge clk) begin
    if (bus.duty_o !== last_duty) begin
      last_duty = bus.duty_o;
      if (exp_duty_q.size() == 0) begin
        vec_cnt++;
        miss_cnt++;
        $display("[TB] FAIL duty_unexpected: got %0d, expected no change", bus.duty_o);
      end else begin
        checkOutput("duty_o", int'(bus.duty_o), exp_duty_q.pop_front());
      end
      if (bus.enable && reset_n) checkOutput("duty_latency_ok", int'((cyc - step_cyc) <= 17), 1);
    end
  end

  // PWM monitor: counts led_out high cycles over one period (compare at pwm_cnt 0..15).
  int acc = 0;
  int contig = 1;
  logic prev_led = 1'b0;
  always @(negedge clk) begin
    logic [PB-1:0] p;
    p = tb_cnt - 1'b1;
    if (p == '0) begin
      acc = int'(bus.led_out);
      contig = 1;
    end else begin
      if (bus.led_out && !prev_led) contig = 0;
      acc += int'(bus.led_out);
    end
    prev_led = bus.led_out;
    if (p == PMAX && exp_high_q.size() != 0) begin
      checkOutput("high_count", acc, exp_high_q.pop_front());
      checkOutput("high_contiguous", contig, 1);
    end
  end

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitCnt(input logic [PB-1:0] v);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tb_cnt == v) return;
    end
    noteTimeout("wait_pwm_cnt");
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_high_q.size() == 0) return;
    end
    noteTimeout("wait_high_drain");
  endtask

  // One step edge, 40 clocks long; expectations are queued before the rising edge.
  task automatic applyStimulus(input int exp_duty, input int exp_phase);
    bus.step_in = 1'b0;
    clocks(20);
    if (exp_duty >= 0)  exp_duty_q.push_back(exp_duty);
    if (exp_phase >= 0) exp_phase_q.push_back(exp_phase);
    bus.step_in = 1'b1;
    step_cyc = cyc;
    clocks(20);
  endtask

  initial begin
    bus.enable  = 1'b0;
    bus.step_in = 1'b1;
    #1 reset_n = 1'b0;
    clocks(3);
    checkOutput("rst_led", int'(bus.led_out), 0);
    checkOutput("rst_duty", int'(bus.duty_o), 0);
    checkOutput("rst_phase", int'(bus.phase_o), 0);
    reset_n = 1'b1;
    clocks(3);
    checkOutput("post_rst_phase", int'(bus.phase_o), 0);
    checkOutput("post_rst_led", int'(bus.led_out), 0);

    // Enable with step_in still high: RAMP_UP but no step counted.
    exp_phase_q.push_back(1);
    bus.enable = 1'b1;
    clocks(10);
    checkOutput("enable_phase", int'(bus.phase_o), 1);
    checkOutput("enable_duty", int'(bus.duty_o), 0);

    // Full breath: 34 edges.
    for (int e = 1; e <= 34; e++) begin
      int d;
      int ph;
      d = -1;
      ph = -1;
      if (e <= 15) d = e;
      else if (e >= 18 && e <= 32) d = 32 - e;
      if (e == 15) ph = 2;
      if (e == 17) ph = 3;
      if (e == 32) ph = 4;
      if (e == 34) ph = 1;
      applyStimulus(d, ph);
    end
    checkOutput("breath_end_phase", int'(bus.phase_o), 1);
    checkOutput("breath_end_duty", int'(bus.duty_o), 0);

    // Freeze at duty 5.
    for (int d = 1; d <= 5; d++) applyStimulus(d, -1);
    waitCnt(4'd8);
    repeat (3) exp_high_q.push_back(5);
    waitDrain();

    // Step edge at pwm_cnt=7 taking duty 5->6.
    bus.step_in = 1'b0;
    waitCnt(4'd7);
    exp_high_q.push_back(5);
    exp_high_q.push_back(6);
    exp_high_q.push_back(6);
    exp_duty_q.push_back(6);
    bus.step_in = 1'b1;
    step_cyc = cyc;
    clocks(20);
    waitDrain();

    // Disable at duty 9 together with a step edge.
    for (int d = 7; d <= 9; d++) applyStimulus(d, -1);
    bus.step_in = 1'b0;
    clocks(3);
    waitCnt(4'd2);
    exp_phase_q.push_back(0);
    exp_duty_q.push_back(0);
    bus.enable = 1'b0;
    bus.step_in = 1'b1;
    step_cyc = cyc;
    @(negedge clk);
    checkOutput("disable_phase", int'(bus.phase_o), 0);
    checkOutput("disable_duty", int'(bus.duty_o), 0);
    @(negedge clk);
    checkOutput("disable_led", int'(bus.led_out), 0);
    clocks(5);
    exp_phase_q.push_back(1);
    bus.enable = 1'b1;
    clocks(3);
    for (int d = 1; d <= 12; d++) applyStimulus(d, -1);

    // Async reset at pwm_cnt=3 with duty 12.
    waitCnt(4'd3);
    checkOutput("led_before_reset", int'(bus.led_out), 1);
    exp_phase_q.push_back(0);
    exp_duty_q.push_back(0);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("async_led", int'(bus.led_out), 0);
    checkOutput("async_duty", int'(bus.duty_o), 0);
    checkOutput("async_phase", int'(bus.phase_o), 0);
    clocks(4);
    checkOutput("hold_rst_led", int'(bus.led_out), 0);
    checkOutput("hold_rst_phase", int'(bus.phase_o), 0);
    reset_n = 1'b1;
    bus.enable = 1'b0;
    clocks(3);
    checkOutput("final_phase", int'(bus.phase_o), 0);
    checkOutput("final_duty", int'(bus.duty_o), 0);

    checkOutput("phase_queue_left", exp_phase_q.size(), 0);
    checkOutput("duty_queue_left", exp_duty_q.size(), 0);
    checkOutput("high_queue_left", exp_high_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
